// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid-buffered pipeline stage.
// The valid/ready handshake, flush-to-bubble and conditional-link write-enable
// qualification happen at capture.
// Optional feature macro: PIPE_STAGE_SKID_STATS_EN adds the stall and flush counters
// behind the stall_cnt/flush_cnt ports. When it is undefined, those ports read 0.
//
// Handshake: an entry transfers upstream when in_valid & in_ready, and downstream
// when out_valid & out_ready. in_ready is a registered copy of (occupancy != 2), so
// it never depends combinationally on out_ready. out_* are registered and hold
// steady while out_valid & ~out_ready.
module pipe_stage_skid #(
   parameter int                 DATA_W     = 96,
   parameter int                 CTRL_W     = 32,
   parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_wr_en,
   input  logic              in_link_cond,
   input  logic              in_link_taken,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_wr_en,
   output logic [1:0]        occupancy,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   // The control bubble value is the low bits of RESET_DATA, zero-extended if CTRL_W is wider.
   localparam logic [CTRL_W-1:0] RESET_CTRL = CTRL_W'(RESET_DATA);

   // The state encoding equals the entry count, so occupancy is the FSM state itself.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic              main_wr_q, main_wr_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              skid_wr_q, skid_wr_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [1:0]        occupancy_q, occupancy_d;

   logic accept;
   logic pop;
   logic wr_qual;

   assign accept  = in_valid & in_ready_q;
   assign pop     = out_valid_q & out_ready;
   // Only the qualified write enable is stored. A conditional link writes only when its branch is taken.
   assign wr_qual = in_wr_en & (~in_link_cond | in_link_taken);

   // Next-state and entry movement. flush overrides any accept or pop in the same cycle.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      main_wr_d   = main_wr_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_wr_d   = skid_wr_q;
      if (flush) begin
         state_d     = S_EMPTY;
         main_data_d = RESET_DATA;
         main_ctrl_d = RESET_CTRL;
         main_wr_d   = 1'b0;
         skid_data_d = RESET_DATA;
         skid_ctrl_d = RESET_CTRL;
         skid_wr_d   = 1'b0;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d     = S_ONE;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
                  main_wr_d   = wr_qual;
               end
            end
            S_ONE: begin
               if (accept && !pop) begin
                  // Head stalls, so the younger entry parks in skid.
                  state_d     = S_TWO;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
                  skid_wr_d   = wr_qual;
               end else if (accept && pop) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
                  main_wr_d   = wr_qual;
               end else if (pop) begin
                  // Draining to empty leaves a bubble on the outputs.
                  state_d     = S_EMPTY;
                  main_data_d = RESET_DATA;
                  main_ctrl_d = RESET_CTRL;
                  main_wr_d   = 1'b0;
               end
            end
            S_TWO: begin
               if (pop) begin
                  state_d     = S_ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  main_wr_d   = skid_wr_q;
                  skid_data_d = RESET_DATA;
                  skid_ctrl_d = RESET_CTRL;
                  skid_wr_d   = 1'b0;
               end
            end
            default: begin
               state_d     = S_EMPTY;
               main_data_d = RESET_DATA;
               main_ctrl_d = RESET_CTRL;
               main_wr_d   = 1'b0;
            end
         endcase
      end
      in_ready_d  = (state_d != S_TWO);
      out_valid_d = (state_d != S_EMPTY);
      occupancy_d = state_d;
   end

   // State, entry storage and registered handshake flags, with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_EMPTY;
         main_data_q <= RESET_DATA;
         main_ctrl_q <= RESET_CTRL;
         main_wr_q   <= 1'b0;
         skid_data_q <= RESET_DATA;
         skid_ctrl_q <= RESET_CTRL;
         skid_wr_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occupancy_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         main_wr_q   <= main_wr_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_wr_q   <= skid_wr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         occupancy_q <= occupancy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;
   assign out_wr_en = main_wr_q;
   assign occupancy = occupancy_q;

`ifdef PIPE_STAGE_SKID_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Counters step by one on each stalled head cycle and on each flush cycle, and wrap naturally.
   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, (out_valid_q & ~out_ready)};
      flush_cnt_d = flush_cnt_q + {31'd0, flush};
   end

   // Counter registers, which are cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = 32'd0;
   assign flush_cnt = 32'd0;
`endif

endmodule
